// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer and the downstream 8-to-32 stage.
package serial_pkg;

    localparam logic [7:0] COM_BC         = 8'hBC;
    localparam int         SYNC_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } serial_state_t;

endpackage

// File: rtl/serial_bits8_if.sv
// Serial lane in, aligned byte out; slave is the deserializer, master is its driver/observer.
interface serial_bits8_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/serial_bits8.sv
// Bit-rate deserializer: hunts for COM, confirms alignment over SYNC_COUNT
// consecutive aligned COMs, then presents each received byte for a full byte period.
module serial_bits8
    import serial_pkg::*;
#(
    parameter logic [7:0] COM        = COM_BC,
    parameter int         SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic          clk_32f,
    input  logic          reset,
    serial_bits8_if.slave bus
);

    localparam logic [2:0] LP_SYNC = 3'(SYNC_COUNT);

    logic [7:0]    r_sr;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    r_bc_cnt;
    serial_state_t r_state;
    logic [7:0]    r_data_out;
    logic          r_valid_out;
    logic          r_active;

    logic [7:0]    w_nxt;
    logic          w_bnd;
    logic          w_is_com;

    // Byte as it will look after this edge, and the aligned-boundary strobe.
    always_comb begin
        w_nxt    = {r_sr[6:0], bus.data_in};
        w_bnd    = (r_bit_cnt == 3'd7);
        w_is_com = (w_nxt == COM);
    end

    // Shift register, bit counter and alignment FSM with registered outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_bc_cnt    <= '0;
            r_state     <= HUNT;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_sr      <= w_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            case (r_state)
                HUNT: begin
                    // Sliding search: any bit position may start a byte.
                    if (w_is_com) begin
                        r_bit_cnt <= '0;
                        r_bc_cnt  <= 3'd1;
                        r_state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (w_bnd) begin
                        if (w_is_com) begin
                            if (r_bc_cnt + 3'd1 == LP_SYNC) begin
                                r_state  <= ACTIVE;
                                r_active <= 1'b1;
                            end else begin
                                r_bc_cnt <= r_bc_cnt + 3'd1;
                            end
                        end else begin
                            r_state  <= HUNT;
                            r_bc_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    // COMs here are idle fill: presented but not flagged valid.
                    if (w_bnd) begin
                        r_data_out  <= w_nxt;
                        r_valid_out <= !w_is_com;
                    end
                end
                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.active    = r_active;

endmodule

// File: tb/tb_serial_bits8.sv
// Directed bench for serial_bits8: reset, alignment, broken sync, payload, idle fill.
module tb_serial_bits8;
    import serial_pkg::*;

    logic clk_32f;
    logic reset;
    int   n_checks;
    int   n_errors;

    serial_bits8_if bus ();

    serial_bits8 #(
        .COM        (COM_BC),
        .SYNC_COUNT (SYNC_COUNT_DEF)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic a);
        check({tag, ".data"},   bus.data_out,         d);
        check({tag, ".valid"},  {7'd0, bus.valid_out}, {7'd0, v});
        check({tag, ".active"}, {7'd0, bus.active},    {7'd0, a});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Sends a byte MSB first; optionally checks outputs hold hd/hv during its first 7 bits.
    task automatic send_byte(input logic [7:0] b, input logic hold_chk,
                             input logic [7:0] hd, input logic hv);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (hold_chk && i != 0) begin
                check("hold.data",  bus.data_out,          hd);
                check("hold.valid", {7'd0, bus.valid_out}, {7'd0, hv});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset = 1'b0;
        @(negedge clk_32f);
        reset = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.data_in = 1'b0;
        #1 reset = 1'b0;

        // Reset held with random lane activity.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_32f);
            bus.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            check_out("rst", 8'h00, 1'b0, 1'b0);
        end
        @(negedge clk_32f);
        reset = 1'b1;

        // Misaligned prefix then four COMs.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
            check_out("prefix.pre", 8'h00, 1'b0, 1'b0);
        end
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        check_out("prefix.sync", 8'h00, 1'b0, 1'b1);

        // Broken sync: third COM followed by FF restarts the hunt.
        do_reset();
        check_out("brk.rst", 8'h00, 1'b0, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        check_out("brk.bc3", 8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 8'h00, 1'b0);
        check_out("brk.ff", 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
            check_out("brk.g2", 8'h00, 1'b0, 1'b0);
        end
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        check_out("brk.sync", 8'h00, 1'b0, 1'b1);

        // Payload with an embedded idle COM.
        send_byte(8'hFF, 1'b1, 8'h00, 1'b0);
        check_out("pay.ff", 8'hFF, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 8'hFF, 1'b1);
        check_out("pay.aa", 8'hAA, 1'b1, 1'b1);
        send_byte(8'hBC, 1'b1, 8'hAA, 1'b1);
        check_out("pay.bc", 8'hBC, 1'b0, 1'b1);
        send_byte(8'hDD, 1'b1, 8'hBC, 1'b0);
        check_out("pay.dd", 8'hDD, 1'b1, 1'b1);

        // Reset three bits into a byte: clears without a clock edge.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b0;
        #1;
        check_out("mid.rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk_32f);
        reset = 1'b1;
        send_byte(8'hCC, 1'b0, 8'h00, 1'b0);
        check_out("mid.cc0", 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
            check_out("mid.bc", 8'h00, 1'b0, 1'b0);
        end
        send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
        check_out("mid.sync", 8'h00, 1'b0, 1'b1);
        send_byte(8'hCC, 1'b1, 8'h00, 1'b0);
        check_out("mid.cc1", 8'hCC, 1'b1, 1'b1);

        // Idle spacing: five COMs then a payload byte.
        send_byte(8'hBC, 1'b1, 8'hCC, 1'b1);
        check_out("idle.bc1", 8'hBC, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC, 1'b1, 8'hBC, 1'b0);
            check_out("idle.bcn", 8'hBC, 1'b0, 1'b1);
        end
        send_byte(8'h01, 1'b1, 8'hBC, 1'b0);
        check_out("idle.01", 8'h01, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
